// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator (ROR, ROL, SHL, SHR, SRA, PASS) with a valid/ready handshake.
// Defining SHIFT_FLAGS_EN adds the flop-driven out_zero and out_carry flags.
module barrel_shift_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [WIDTH-1:0]         in_a,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_z
`ifdef SHIFT_FLAGS_EN
    ,
    output logic                     out_zero,
    output logic                     out_carry
`endif
);

    localparam int LW = $clog2(WIDTH);
    localparam int P  = PIPE_STAGES;

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    // Handshake: a request is taken on a rising edge where in_valid & in_ready, a
    // result leaves where out_valid & out_ready. The whole pipe freezes while the
    // output rank holds a result nobody takes, so in_ready is simply ~stall.
    logic stall;

    logic             valid_q [P];
    logic             valid_d [P];
    logic [2:0]       op_q    [P];
    logic [2:0]       op_d    [P];
    logic [LW-1:0]    amt_q   [P];
    logic [LW-1:0]    amt_d   [P];
    logic [WIDTH-1:0] data_q  [P];
    logic [WIDTH-1:0] data_d  [P];

    logic             src_valid;
    logic [2:0]       src_op;
    logic [LW-1:0]    src_amt;
    logic [WIDTH-1:0] shift_t;

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [2:0] op,
                                                     input int s);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
            OP_SHL:  r = d << s;
            OP_SHR:  r = d >> s;
            OP_SRA:  r = WIDTH'($signed(d) >>> s);
            default: r = d;
        endcase
        return r;
    endfunction

    // First mux level owned by rank r; rank r covers [level_lo(r), level_lo(r+1)).
    function automatic int level_lo(input int r);
        return (r * LW) / P;
    endfunction

    assign stall    = valid_q[P-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        src_valid = 1'b0;
        src_op    = '0;
        src_amt   = '0;
        shift_t   = '0;
        for (int r = 0; r < P; r++) begin
            if (r == 0) begin
                src_valid = in_valid;
                src_op    = in_op;
                src_amt   = in_amt;
                shift_t   = in_a;
            end else begin
                src_valid = valid_q[(r > 0) ? r - 1 : 0];
                src_op    = op_q[(r > 0) ? r - 1 : 0];
                src_amt   = amt_q[(r > 0) ? r - 1 : 0];
                shift_t   = data_q[(r > 0) ? r - 1 : 0];
            end
            for (int k = 0; k < LW; k++) begin
                if (k >= level_lo(r) && k < level_lo(r + 1) && src_amt[k]) begin
                    shift_t = shift_level(shift_t, src_op, 1 << k);
                end
            end
            valid_d[r] = stall ? valid_q[r] : src_valid;
            op_d[r]    = stall ? op_q[r]    : src_op;
            amt_d[r]   = stall ? amt_q[r]   : src_amt;
            data_d[r]  = stall ? data_q[r]  : shift_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < P; r++) begin
                valid_q[r] <= 1'b0;
                op_q[r]    <= '0;
                amt_q[r]   <= '0;
                data_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < P; r++) begin
                valid_q[r] <= valid_d[r];
                op_q[r]    <= op_d[r];
                amt_q[r]   <= amt_d[r];
                data_q[r]  <= data_d[r];
            end
        end
    end

    assign out_valid = valid_q[P-1];
    assign out_z     = data_q[P-1];

`ifdef SHIFT_FLAGS_EN
    // The carry is a pure function of the request, so it is resolved at the input
    // and then rides along with the data.
    logic          carry_q [P];
    logic          carry_d [P];
    logic          carry_in;
    logic          zero_q;
    logic          zero_d;
    logic [LW-1:0] idx_r;
    logic [LW-1:0] idx_l;

    always_comb begin
        idx_r    = in_amt - LW'(1);
        idx_l    = LW'(0) - in_amt;
        carry_in = 1'b0;
        if (in_amt != '0) begin
            case (in_op)
                OP_ROR, OP_SHR, OP_SRA: carry_in = in_a[idx_r];
                OP_ROL, OP_SHL:         carry_in = in_a[idx_l];
                default:                carry_in = 1'b0;
            endcase
        end
        for (int r = 0; r < P; r++) begin
            if (r == 0) begin
                carry_d[r] = stall ? carry_q[r] : carry_in;
            end else begin
                carry_d[r] = stall ? carry_q[r] : carry_q[(r > 0) ? r - 1 : 0];
            end
        end
        zero_d = (data_d[P-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < P; r++) begin
                carry_q[r] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else begin
            for (int r = 0; r < P; r++) begin
                carry_q[r] <= carry_d[r];
            end
            zero_q <= zero_d;
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = carry_q[P-1];
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=32, PIPE_STAGES=2): directed cases,
// burst, stall, reset-in-flight and randomized traffic against a behavioural model.
module tb_barrel_shift_pipe;

    localparam int W  = 32;
    localparam int P  = 2;
    localparam int LW = 5;

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [LW-1:0] in_amt = '0;
    logic [W-1:0]  in_a = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_z;
`ifdef SHIFT_FLAGS_EN
    logic          out_zero;
    logic          out_carry;
    logic          exp_carry_q[$];
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_cnt = 0;
    int out_cyc_q[$];
    logic [W-1:0] exp_q[$];

    barrel_shift_pipe #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z)
`ifdef SHIFT_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: rotates via a doubled operand, SRA via an explicit fill mask.
    function automatic logic [W-1:0] model_z(input logic [2:0] op, input int amt, input logic [W-1:0] a);
        logic [2*W-1:0] dbl;
        logic [2*W-1:0] tmp;
        dbl = {a, a};
        case (op)
            OP_ROR: begin tmp = dbl >> amt; return tmp[W-1:0]; end
            OP_ROL: begin tmp = dbl << amt; return tmp[2*W-1:W]; end
            OP_SHL: return a << amt;
            OP_SHR: return a >> amt;
            OP_SRA: return (a >> amt) | (a[W-1] ? ~({W{1'b1}} >> amt) : {W{1'b0}});
            default: return a;
        endcase
    endfunction

`ifdef SHIFT_FLAGS_EN
    function automatic logic model_carry(input logic [2:0] op, input int amt, input logic [W-1:0] a);
        logic [W-1:0] z;
        z = model_z(op, amt, a);
        if (amt == 0) return 1'b0;
        case (op)
            OP_SHR, OP_SRA: return a[amt-1];
            OP_SHL:         return a[W-amt];
            OP_ROR:         return z[W-1];
            OP_ROL:         return z[0];
            default:        return 1'b0;
        endcase
    endfunction
`endif

    task automatic monitor();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                out_cnt++;
                out_cyc_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got=%h required=none", out_z);
                end else begin
                    e = exp_q.pop_front();
                    if (out_z !== e) begin
                        failures++;
                        $display("FAIL result_z got=%h required=%h", out_z, e);
                    end
`ifdef SHIFT_FLAGS_EN
                    checks++;
                    if (out_zero !== (e == '0)) begin
                        failures++;
                        $display("FAIL result_zero got=%b required=%b", out_zero, (e == '0));
                    end
                    if (exp_carry_q.size() != 0) begin
                        checks++;
                        if (out_carry !== exp_carry_q[0]) begin
                            failures++;
                            $display("FAIL result_carry got=%b required=%b", out_carry, exp_carry_q[0]);
                        end
                        void'(exp_carry_q.pop_front());
                    end
`endif
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input int amt, input logic [W-1:0] a);
        int  waited;
        bit  acc;
        in_valid = 1'b1;
        in_op    = op;
        in_amt   = LW'(amt);
        in_a     = a;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            waited++;
        end
        checks++;
        if (acc) begin
            exp_q.push_back(model_z(op, amt, a));
`ifdef SHIFT_FLAGS_EN
            exp_carry_q.push_back(model_carry(op, amt, a));
`endif
        end else begin
            failures++;
            $display("FAIL accept_timeout got=in_ready_low required=accept_within_100");
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d_pending required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_z !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=valid%b_z%h required=valid0_z0", out_valid, out_z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=ready%b_valid%b required=ready1_valid0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [2:0] op, input int amt, input logic [W-1:0] a,
                            input logic [W-1:0] expz);
        wait_idle();
        send(op, amt, a);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early op=%0d got=valid%b required=valid0", op, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_z !== expz) begin
            failures++;
            $display("FAIL directed op=%0d amt=%0d got=valid%b_z%h required=valid1_z%h",
                     op, amt, out_valid, out_z, expz);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        directed(OP_ROR, 1, 32'h8000_0001, 32'hC000_0000);
        directed(OP_ROL, 4, 32'h8000_0001, 32'h0000_0018);
        directed(OP_SRA, 31, 32'h8000_0000, 32'hFFFF_FFFF);
        directed(OP_SHR, 31, 32'h8000_0000, 32'h0000_0001);
        directed(3'b111, 9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        directed(OP_SRA, 0, 32'h8765_4321, 32'h8765_4321);
        directed(OP_ROL, 0, 32'h1234_5678, 32'h1234_5678);
        drain();
    endtask

`ifdef SHIFT_FLAGS_EN
    task automatic flag_case(input logic [2:0] op, input int amt, input logic [W-1:0] a,
                             input logic [W-1:0] expz, input logic expzero, input logic expcarry);
        wait_idle();
        send(op, amt, a);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_z !== expz || out_zero !== expzero || out_carry !== expcarry) begin
            failures++;
            $display("FAIL flags op=%0d amt=%0d got=z%h_zero%b_carry%b required=z%h_zero%b_carry%b",
                     op, amt, out_z, out_zero, out_carry, expz, expzero, expcarry);
        end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        flag_case(OP_SHR, 1, 32'h3, 32'h1, 1'b0, 1'b1);
        flag_case(OP_SHL, 31, 32'h1, 32'h8000_0000, 1'b0, 1'b0);
        flag_case(OP_SHR, 1, 32'h1, 32'h0, 1'b1, 1'b1);
        drain();
    endtask
`endif

    task automatic test_back_to_back();
        out_ready = 1'b1;
        wait_idle();
        out_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(OP_SHL, i, 32'h1);
        end
        drain();
        checks++;
        if (out_cyc_q.size() != 8) begin
            failures++;
            $display("FAIL burst_count got=%0d required=8", out_cyc_q.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (out_cyc_q[i] != out_cyc_q[i-1] + 1) begin
                    failures++;
                    $display("FAIL burst_spacing idx=%0d got=%0d required=1", i, out_cyc_q[i] - out_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int           n0;
        bit           seen;
        logic [W-1:0] held;
        wait_idle();
        out_ready = 1'b0;
        n0 = out_cnt;
        held = '0;
        fork
            begin
                send(OP_SHL, 3, 32'h0000_0011);
                send(OP_ROR, 8, 32'h1234_5678);
                send(OP_SRA, 4, 32'h8000_0010);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = (out_valid === 1'b1);
                end
                checks++;
                if (!seen) begin
                    failures++;
                    $display("FAIL stall_first_valid got=0 required=1");
                end
                if (exp_q.size() != 0) held = exp_q[0];
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_z !== held) begin
                        failures++;
                        $display("FAIL stall_hold cyc=%0d got=ready%b_valid%b_z%h required=ready0_valid1_z%h",
                                 i, in_ready, out_valid, out_z, held);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (out_cnt - n0 != 3) begin
            failures++;
            $display("FAIL stall_count got=%0d required=3", out_cnt - n0);
        end
    endtask

    task automatic test_reset_inflight();
        int n0;
        out_ready = 1'b1;
        wait_idle();
        send(OP_ROL, 5, 32'hA5A5_0F0F);
        send(OP_SHR, 2, 32'hFFFF_0000);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_z !== '0) begin
            failures++;
            $display("FAIL reset_inflight got=valid%b_z%h required=valid0_z0", out_valid, out_z);
        end
        exp_q.delete();
`ifdef SHIFT_FLAGS_EN
        exp_carry_q.delete();
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = out_cnt;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_cnt != n0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_stale got=%0d_results required=0", out_cnt - n0);
        end
    endtask

    task automatic test_random();
        bit done;
        int n0;
        done = 1'b0;
        n0 = out_cnt;
        wait_idle();
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    int amt;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 5))
                        0:       amt = 0;
                        1:       amt = W - 1;
                        default: amt = $urandom_range(0, W - 1);
                    endcase
                    send(3'($urandom_range(0, 7)), amt, $urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (out_cnt - n0 != 150) begin
            failures++;
            $display("FAIL random_count got=%0d required=150", out_cnt - n0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_directed();
`ifdef SHIFT_FLAGS_EN
        test_flags();
`endif
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
